// File: rtl/traffic_phase_sequencer.sv
// Two-road junction lamp sequencer: eight-phase cycle plus night blink mode.
// Define PED_REQ_EN to let a pedestrian request cut main green short after T_MIN_G ticks.
module traffic_phase_sequencer #(
    parameter int TICK_DIV = 10_000_000,
    parameter int DIV_W    = 24,
    parameter int CNT_W    = 10,
    parameter int T_MAIN_G = 450,
    parameter int T_YEL    = 50,
    parameter int T_TURN   = 250,
    parameter int T_SIDE_G = 250,
    parameter int T_BLINK  = 10,
    parameter int T_MIN_G  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink,
    input  logic       ped_req,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       main_rt,
    output logic       side_rt,
    output logic [3:0] phase,
    output logic       ped_wait
);

    typedef enum logic [3:0] {
        S_MG    = 4'd0,
        S_MY    = 4'd1,
        S_MRT   = 4'd2,
        S_MY2   = 4'd3,
        S_SG    = 4'd4,
        S_SY    = 4'd5,
        S_SRT   = 4'd6,
        S_SY2   = 4'd7,
        S_BLINK = 4'd8
    } state_e;

    localparam logic [DIV_W-1:0] PRE_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MG_LAST    = CNT_W'(T_MAIN_G - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(T_TURN - 1);
    localparam logic [CNT_W-1:0] SG_LAST    = CNT_W'(T_SIDE_G - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(T_BLINK - 1);

    // Plain vector rather than the enum type so out-of-range codes stay representable.
    logic [3:0]       state, state_nx;
    logic [DIV_W-1:0] pre;
    logic [CNT_W-1:0] cnt, dur_last;
    logic             blink_ph;
    logic             tick, expire, ped_exit;
    logic [2:0]       main_d, side_d;
    logic             mrt_d, srt_d;

    assign tick   = (pre == PRE_LAST);
    assign expire = tick && (cnt == dur_last);
    assign phase  = state;

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_G - 1);
    assign ped_exit = tick && ped_wait && (state == S_MG) && (cnt >= MIN_LAST);
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_exit   = 1'b0;
`endif

    always_comb begin
        case (state)
            S_MG:                      dur_last = MG_LAST;
            S_MY, S_MY2, S_SY, S_SY2:  dur_last = YEL_LAST;
            S_MRT, S_SRT:              dur_last = TURN_LAST;
            S_SG:                      dur_last = SG_LAST;
            default:                   dur_last = BLINK_LAST;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (state > S_BLINK)
            state_nx = S_MG;
        else if (state == S_BLINK) begin
            if (!blink) state_nx = S_MG;
        end else if (blink)
            state_nx = S_BLINK;
        else if (expire || ped_exit)
            state_nx = {1'b0, state[2:0] + 3'd1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_MG;
        else      state <= state_nx;
    end

    // Every state entry restarts the prescaler, so a phase is exactly T_x * TICK_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre      <= '0;
            cnt      <= '0;
            blink_ph <= 1'b0;
        end else if (state_nx != state) begin
            pre      <= '0;
            cnt      <= '0;
            blink_ph <= 1'b0;
        end else if (tick) begin
            pre <= '0;
            if (state == S_BLINK && cnt == BLINK_LAST) begin
                cnt      <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_comb begin
        main_d = 3'b100;
        side_d = 3'b100;
        mrt_d  = 1'b0;
        srt_d  = 1'b0;
        case (state)
            S_MY, S_MY2: main_d = 3'b010;
            S_MRT:       mrt_d  = 1'b1;
            S_SG:        side_d = 3'b001;
            S_SY:        side_d = 3'b010;
            S_SRT:       srt_d  = 1'b1;
            S_SY2:       side_d = 3'b110;
            S_BLINK: begin
                main_d = {1'b0, ~blink_ph, 1'b0};
                side_d = {1'b0, ~blink_ph, 1'b0};
            end
            default:     main_d = 3'b001;  // S_MG and illegal codes
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_lamp <= 3'b000;
            side_lamp <= 3'b000;
            main_rt   <= 1'b0;
            side_rt   <= 1'b0;
        end else begin
            main_lamp <= main_d;
            side_lamp <= side_d;
            main_rt   <= mrt_d;
            side_rt   <= srt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ped_wait <= 1'b0;
`ifdef PED_REQ_EN
        else if (state == S_BLINK)
            ped_wait <= 1'b0;
        else if (state_nx == S_SG && state != S_SG)
            ped_wait <= 1'b0;
        else if (ped_req)
            ped_wait <= 1'b1;
`else
        else
            ped_wait <= 1'b0;
`endif
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with small timing parameters (TICK_DIV=4).
// Honours PED_REQ_EN the same way the design does.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       blink = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_lamp, side_lamp;
    logic       main_rt, side_rt;
    logic [3:0] phase;
    logic       ped_wait;

    int checks = 0;
    int errors = 0;
    int n;

`ifdef PED_REQ_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    // Expected lamps per phase 0..7, and phase lengths in ticks.
    int exp_main[8] = '{1, 2, 4, 2, 4, 4, 4, 4};
    int exp_side[8] = '{4, 4, 4, 4, 1, 2, 4, 6};
    int exp_mrt[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    int exp_srt[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    int dur[8]      = '{5, 2, 3, 2, 3, 2, 3, 2};

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .TICK_DIV(4), .DIV_W(3), .CNT_W(4), .T_MAIN_G(5), .T_YEL(2),
        .T_TURN(3), .T_SIDE_G(3), .T_BLINK(2), .T_MIN_G(2)
    ) dut (
        .clk(clk), .rst(rst), .blink(blink), .ped_req(ped_req),
        .main_lamp(main_lamp), .side_lamp(side_lamp),
        .main_rt(main_rt), .side_rt(side_rt),
        .phase(phase), .ped_wait(ped_wait)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [3:0] p, output int cycles);
        cycles = 0;
        while (phase !== p && cycles < 300) begin
            step();
            cycles++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_main"}, int'(main_lamp), 0);
        chk({tag, "_side"}, int'(side_lamp), 0);
        chk({tag, "_rt"}, int'({main_rt, side_rt}), 0);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_pw"}, int'(ped_wait), 0);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk_all_zero("reset");

        // Release: first edge shows S_MG lamps, then walk the whole cycle
        rst = 1'b1;
        step();
        chk("first_main", int'(main_lamp), 1);
        chk("first_side", int'(side_lamp), 4);
        for (int i = 1; i <= 8; i++) begin
            wait_phase(4'(i % 8), n);
            chk($sformatf("len_ph%0d", i - 1), n, dur[i - 1] * 4 - 1);
            step();
            chk($sformatf("main_ph%0d", i % 8), int'(main_lamp), exp_main[i % 8]);
            chk($sformatf("side_ph%0d", i % 8), int'(side_lamp), exp_side[i % 8]);
            chk($sformatf("mrt_ph%0d", i % 8), int'(main_rt), exp_mrt[i % 8]);
            chk($sformatf("srt_ph%0d", i % 8), int'(side_rt), exp_srt[i % 8]);
        end

        // Blink during S_SG
        wait_phase(4'd4, n);
        chk("to_sg_len", n, 19 + 8 + 12 + 8);
        step(); step();
        blink = 1'b1;
        step();
        chk("blink_phase", int'(phase), 8);
        step();
        chk("blink_main_on", int'(main_lamp), 2);
        chk("blink_side_on", int'(side_lamp), 2);
        chk("blink_rt", int'({main_rt, side_rt}), 0);
        n = 0;
        while (main_lamp === 3'b010 && n < 50) begin step(); n++; end
        chk("blink_on_len", n, 8);
        chk("blink_main_off", int'(main_lamp), 0);
        chk("blink_side_off", int'(side_lamp), 0);
        n = 0;
        while (main_lamp === 3'b000 && n < 50) begin step(); n++; end
        chk("blink_off_len", n, 8);
        chk("blink_side_on2", int'(side_lamp), 2);
        blink = 1'b0;
        step();
        chk("unblink_phase", int'(phase), 0);
        step();
        chk("unblink_main", int'(main_lamp), 1);
        wait_phase(4'd1, n);
        chk("unblink_mg_len", n, 19);

        // Blink rises on the very edge S_MY would expire
        repeat (7) step();
        chk("my_before_expiry", int'(phase), 1);
        blink = 1'b1;
        step();
        chk("blink_over_expiry", int'(phase), 8);
        blink = 1'b0;
        step();
        chk("back_to_mg", int'(phase), 0);

        // Pedestrian request at clk 1 of S_MG
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped_wait_set", int'(ped_wait), int'(PED));
        wait_phase(4'd1, n);
        chk("ped_mg_len", n, PED ? 7 : 19);
        wait_phase(4'd3, n);
        chk("ped_to_my2", n, 20);
        chk("ped_wait_held", int'(ped_wait), int'(PED));
        wait_phase(4'd4, n);
        chk("ped_to_sg", n, 8);
        chk("ped_wait_clr", int'(ped_wait), 0);

        // Asynchronous reset in the middle of S_SRT
        wait_phase(4'd6, n);
        chk("to_srt", n, 20);
        repeat (3) step();
        #3 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        step();
        rst = 1'b1;
        wait_phase(4'd1, n);
        chk("post_rst_mg_len", n, 20);

        // Illegal state code recovers to S_MG
        step();
        force dut.state = 4'd12;
        #1 chk("forced_phase", int'(phase), 12);
        release dut.state;
        step();
        chk("illegal_to_mg", int'(phase), 0);
        step();
        chk("illegal_main", int'(main_lamp), 1);
        chk("illegal_side", int'(side_lamp), 4);
        wait_phase(4'd1, n);
        chk("illegal_mg_len", n, 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
